// File: rtl/pwm_pkg.sv
// Shared encodings for the multi-channel PWM controller.
package pwm_pkg;

  localparam int CH_IDX_W = 8;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: shadow/active parameter sets, up or up/down counter, compare.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic             en_i,
  input  pwm_mode_e        mode_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] hlevel_i,
  input  logic             sync_i,
  output logic             pwm_o,
  output logic             period_end_o
);

  logic             shd_en_q, act_en_q;
  pwm_mode_e        shd_mode_q, act_mode_q;
  logic [CNT_W-1:0] shd_p_q, shd_h_q, act_p_q, act_h_q;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;   // 1 = counting down
  logic             pwm_q, pwm_d;
  logic             pe_q, pe_d;

  logic             p_zero, center, at_top, wrap, bnd;
  logic [CNT_W-1:0] p_m1;

  // Center mode only differs from edge mode once there is a real down-slope (P>=3).
  assign p_zero = (act_p_q == '0);
  assign p_m1   = p_zero ? '0 : act_p_q - CNT_W'(1);
  assign center = (act_mode_q == MODE_CENTER) && (act_p_q > CNT_W'(2));
  assign at_top = (cnt_q == p_m1);

  always_comb begin
    wrap = 1'b0;
    if (p_zero)      wrap = 1'b1;
    else if (center) wrap = dir_q && (cnt_q == CNT_W'(1));
    else             wrap = at_top;
  end

  assign bnd = wrap || sync_i;

  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    pend_d = pend_q;
    if (bnd) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (center && dir_q) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (center && at_top) begin
      cnt_d = cnt_q - CNT_W'(1);
      dir_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // A write landing on a boundary stays pending for the following boundary.
    if (wr_i)     pend_d = 1'b1;
    else if (bnd) pend_d = 1'b0;
    pwm_d = act_en_q && !p_zero && (cnt_q < act_h_q);
    pe_d  = bnd && act_en_q && !p_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shd_en_q   <= 1'b0;
      shd_mode_q <= MODE_EDGE;
      shd_p_q    <= '0;
      shd_h_q    <= '0;
      act_en_q   <= 1'b0;
      act_mode_q <= MODE_EDGE;
      act_p_q    <= '0;
      act_h_q    <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      pwm_q      <= 1'b0;
      pe_q       <= 1'b0;
    end else begin
      if (wr_i) begin
        shd_en_q   <= en_i;
        shd_mode_q <= mode_i;
        shd_p_q    <= period_i;
        shd_h_q    <= hlevel_i;
      end
      if (bnd && pend_q) begin
        act_en_q   <= shd_en_q;
        act_mode_q <= shd_mode_q;
        act_p_q    <= shd_p_q;
        act_h_q    <= shd_h_q;
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      pwm_q  <= pwm_d;
      pe_q   <= pe_d;
    end
  end

  assign pwm_o        = pwm_q;
  assign period_end_o = pe_q;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM controller: config-write decode and sync fan-out to pwm_chan instances.
module pwm_multi_ctrl
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_vld,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic                cfg_en,
  input  logic                cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_hlevel,
  input  logic                sync,
  output logic [NUM_CH-1:0]   pwm,
  output logic [NUM_CH-1:0]   period_end
);

  logic [NUM_CH-1:0] wr;

  // Out-of-range channel indices match no instance and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = cfg_vld && (cfg_ch == CH_IDX_W'(i));

    pwm_chan #(.CNT_W(CNT_W)) u_chan (
      .clk          (clk),
      .rst          (rst),
      .wr_i         (wr[i]),
      .en_i         (cfg_en),
      .mode_i       (pwm_mode_e'(cfg_mode)),
      .period_i     (cfg_period),
      .hlevel_i     (cfg_hlevel),
      .sync_i       (sync),
      .pwm_o        (pwm[i]),
      .period_end_o (period_end[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl with hand-derived waveforms.
module tb_pwm_multi_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 28;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_vld;
  logic [7:0]        cfg_ch;
  logic              cfg_en;
  logic              cfg_mode;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_hlevel;
  logic              sync;
  logic [NUM_CH-1:0] pwm;
  logic [NUM_CH-1:0] period_end;

  int checks = 0;
  int errors = 0;

  pwm_multi_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_vld    (cfg_vld),
    .cfg_ch     (cfg_ch),
    .cfg_en     (cfg_en),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_hlevel (cfg_hlevel),
    .sync       (sync),
    .pwm        (pwm),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  task automatic cfg_write(input int ch, input logic en, input logic mode,
                           input int p, input int h);
    cfg_vld    = 1'b1;
    cfg_ch     = 8'(ch);
    cfg_en     = en;
    cfg_mode   = mode;
    cfg_period = CNT_W'(p);
    cfg_hlevel = CNT_W'(h);
    @(negedge clk);
    cfg_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pe(input int ch);
    bit got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (period_end[ch]) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_pe ch%0d: period_end never seen in 200 cycles, required a pulse", ch);
    end
  endtask

  // Index 0 is the current cycle; further samples one per falling edge.
  task automatic sample_win(input int ch, input int n, output logic [31:0] bits,
                            output int pecnt);
    bits  = '0;
    pecnt = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      bits[k] = pwm[ch];
      pecnt += int'(period_end[ch]);
    end
  endtask

  task automatic test_reset();
    logic [NUM_CH-1:0] acc;
    cfg_vld = 1'b1; cfg_ch = 8'd0; cfg_en = 1'b1; cfg_mode = 1'b0;
    cfg_period = CNT_W'(3); cfg_hlevel = CNT_W'(2); sync = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pwm, period_end} !== '0) begin
      errors++;
      $display("FAIL reset_out: pwm=%b pe=%b, required 0", pwm, period_end);
    end
    rst = 1'b0; cfg_vld = 1'b0; sync = 1'b0;
    acc = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc |= pwm | period_end;
    end
    checks++;
    if (acc !== '0) begin
      errors++;
      $display("FAIL reset_prio: outputs active %b after rst+cfg_vld, required 0", acc);
    end
  endtask

  task automatic test_edge();
    logic [31:0] bits;
    int pc;
    cfg_write(1, 1'b1, 1'b0, 10, 3);
    wait_pe(1);
    sample_win(1, 10, bits, pc);
    checks++;
    if (bits[9:0] !== 10'b0000001110) begin
      errors++;
      $display("FAIL edge_pwm: got %b, required %b", bits[9:0], 10'b0000001110);
    end
    checks++;
    if (pc != 1) begin
      errors++;
      $display("FAIL edge_pe_cnt: got %0d pulses in window, required 1", pc);
    end
    @(negedge clk);
    checks++;
    if (period_end[1] !== 1'b1) begin
      errors++;
      $display("FAIL edge_pe_period: got %b at cycle 10, required 1", period_end[1]);
    end
  endtask

  task automatic test_center();
    logic [31:0] bits;
    int pc;
    cfg_write(2, 1'b1, 1'b1, 5, 2);
    wait_pe(2);
    sample_win(2, 8, bits, pc);
    checks++;
    if (bits[7:0] !== 8'b00000111) begin
      errors++;
      $display("FAIL center_pwm: got %b, required %b", bits[7:0], 8'b00000111);
    end
    checks++;
    if (pc != 1) begin
      errors++;
      $display("FAIL center_pe_cnt: got %0d pulses in window, required 1", pc);
    end
    @(negedge clk);
    checks++;
    if (period_end[2] !== 1'b1) begin
      errors++;
      $display("FAIL center_pe_period: got %b at cycle 8, required 1", period_end[2]);
    end
  endtask

  task automatic test_update();
    logic [31:0] bits;
    logic [9:0]  cur;
    int pc;
    do_reset();
    cfg_write(0, 1'b1, 1'b0, 10, 3);
    wait_pe(0);
    cur = '0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      cur[k] = pwm[0];
      if (k == 4) begin
        cfg_vld = 1'b1; cfg_ch = 8'd0; cfg_en = 1'b1; cfg_mode = 1'b0;
        cfg_period = CNT_W'(10); cfg_hlevel = CNT_W'(7);
      end else begin
        cfg_vld = 1'b0;
      end
    end
    checks++;
    if (cur !== 10'b0000001110) begin
      errors++;
      $display("FAIL update_cur: got %b, required %b", cur, 10'b0000001110);
    end
    @(negedge clk);
    checks++;
    if (period_end[0] !== 1'b1) begin
      errors++;
      $display("FAIL update_pe: got %b, required 1", period_end[0]);
    end
    sample_win(0, 10, bits, pc);
    checks++;
    if (bits[9:0] !== 10'b0011111110) begin
      errors++;
      $display("FAIL update_next: got %b, required %b", bits[9:0], 10'b0011111110);
    end
  endtask

  task automatic test_limits();
    logic [31:0] bits;
    int pc;
    do_reset();
    cfg_write(3, 1'b1, 1'b0, 10, 12);
    repeat (5) @(negedge clk);
    sample_win(3, 20, bits, pc);
    checks++;
    if (bits[19:0] !== 20'hFFFFF) begin
      errors++;
      $display("FAIL h_over_p: got %h, required fffff", bits[19:0]);
    end
    checks++;
    if (pc != 2) begin
      errors++;
      $display("FAIL h_over_p_pe: got %0d pulses, required 2", pc);
    end
    cfg_write(3, 1'b1, 1'b0, 10, 0);
    repeat (15) @(negedge clk);
    sample_win(3, 20, bits, pc);
    checks++;
    if (bits[19:0] !== 20'h0) begin
      errors++;
      $display("FAIL h_zero: got %h, required 00000", bits[19:0]);
    end
    checks++;
    if (pc != 2) begin
      errors++;
      $display("FAIL h_zero_pe: got %0d pulses, required 2", pc);
    end
    cfg_write(3, 1'b1, 1'b0, 0, 5);
    repeat (15) @(negedge clk);
    sample_win(3, 20, bits, pc);
    checks++;
    if (bits[19:0] !== 20'h0) begin
      errors++;
      $display("FAIL p_zero_pwm: got %h, required 00000", bits[19:0]);
    end
    checks++;
    if (pc != 0) begin
      errors++;
      $display("FAIL p_zero_pe: got %0d pulses, required 0", pc);
    end
  endtask

  task automatic test_ignore();
    logic [NUM_CH-1:0] acc;
    do_reset();
    cfg_write(4, 1'b1, 1'b0, 4, 2);
    cfg_write(5, 1'b1, 1'b1, 4, 2);
    cfg_write(255, 1'b1, 1'b0, 3, 1);
    acc = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc |= pwm | period_end;
    end
    checks++;
    if (acc !== '0) begin
      errors++;
      $display("FAIL ignore_oor: outputs active %b, required 0", acc);
    end
  endtask

  task automatic test_sync();
    logic [12:0] pe0, pe3;
    logic [1:0]  pw;
    do_reset();
    cfg_write(0, 1'b1, 1'b0, 10, 3);
    cfg_write(3, 1'b1, 1'b0, 6, 3);
    repeat (13) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    pe0 = '0; pe3 = '0; pw = '0;
    for (int k = 0; k < 13; k++) begin
      if (k > 0) @(negedge clk);
      pe0[k] = period_end[0];
      pe3[k] = period_end[3];
      if (k == 1) pw = {pwm[3], pwm[0]};
    end
    checks++;
    if (pe0 !== 13'b0010000000001) begin
      errors++;
      $display("FAIL sync_pe0: got %b, required %b", pe0, 13'b0010000000001);
    end
    checks++;
    if (pe3 !== 13'b1000001000001) begin
      errors++;
      $display("FAIL sync_pe3: got %b, required %b", pe3, 13'b1000001000001);
    end
    checks++;
    if (pw !== 2'b11) begin
      errors++;
      $display("FAIL sync_pwm: got %b, required 11", pw);
    end
  endtask

  task automatic test_rst_mid();
    logic [NUM_CH-1:0] acc;
    do_reset();
    cfg_write(0, 1'b1, 1'b0, 10, 3);
    wait_pe(0);
    @(negedge clk);
    checks++;
    if (pwm[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: pwm0=%b, required 1", pwm[0]);
    end
    cfg_write(0, 1'b1, 1'b0, 10, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({pwm, period_end} !== '0) begin
      errors++;
      $display("FAIL rst_mid_out: pwm=%b pe=%b, required 0", pwm, period_end);
    end
    acc = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      acc |= pwm | period_end;
    end
    checks++;
    if (acc !== '0) begin
      errors++;
      $display("FAIL rst_mid_after: outputs active %b, required 0", acc);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_vld = 1'b0; cfg_ch = '0; cfg_en = 1'b0; cfg_mode = 1'b0;
    cfg_period = '0; cfg_hlevel = '0; sync = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_edge();
    test_center();
    test_update();
    test_limits();
    test_ignore();
    test_sync();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
